fns_weight_sched: RTL and testbench

- Sequential configuration controller for the Fibonacci-numeral-system (FNS) TSV link.
- On request, it walks the TSV fault-flag vector one TSV per cycle and assigns a Fibonacci weight to each enabled TSV.
- Faulty TSVs are skipped. Healthy TSVs beyond the required signal count are parked as disabled spares.
- It publishes the enable mask, the per-TSV weight vector and a pass/fail status that the codec stages consume.

---
 rtl/fns_weight_sched_if.sv | 25 ++
 rtl/fns_weight_sched.sv | 130 +++++++++++++
 tb/tb_fns_weight_sched.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fns_weight_sched_if.sv
// Handshake and configuration bundle between the FNS weight scheduler and its user.
// The master side requests scans and the slave side publishes the resulting TSV configuration.
interface fns_weight_sched_if #(
  parameter int NTSV = 5,
  parameter int WLEN = 4
);
  logic                   start;
  logic [NTSV-1:0]        f_flag;
  logic                   busy;
  logic                   done;
  logic                   fail;
  logic                   cfg_valid;
  logic [NTSV-1:0]        en_flag;
  logic [NTSV*WLEN-1:0]   weights;

  modport master (
    output start, f_flag,
    input  busy, done, fail, cfg_valid, en_flag, weights
  );

  modport slave (
    input  start, f_flag,
    output busy, done, fail, cfg_valid, en_flag, weights
  );
endinterface

// File: rtl/fns_weight_sched.sv
// Walks the latched TSV fault vector one TSV per cycle and hands out Fibonacci weights
// 1,2,3,5,... to the first NSIG healthy TSVs; later healthy TSVs are parked as spares.
module fns_weight_sched #(
  parameter int NTSV = 5,
  parameter int NSIG = 3,
  parameter int WLEN = 4
) (
  input  logic               clk,
  input  logic               rst,
  fns_weight_sched_if.slave  bus
);
  localparam int IDXW = (NTSV > 1) ? $clog2(NTSV) : 1;
  localparam int CNTW = $clog2(NSIG + 1);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NTSV - 1);
  localparam logic [CNTW-1:0] NSIG_C   = CNTW'(NSIG);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t               state_q, state_d;
  logic [IDXW-1:0]      idx_q, idx_d;
  logic [CNTW-1:0]      cnt_q, cnt_d;
  logic [WLEN-1:0]      a_q, a_d;
  logic [WLEN-1:0]      b_q, b_d;
  logic [WLEN-1:0]      sum;
  logic [NTSV-1:0]      flag_q, flag_d;
  logic [NTSV-1:0]      en_q, en_d;
  logic [NTSV*WLEN-1:0] weights_q, weights_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 fail_q, fail_d;
  logic                 cfg_valid_q, cfg_valid_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      flag_q      <= '0;
      en_q        <= '0;
      weights_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      cfg_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      flag_q      <= flag_d;
      en_q        <= en_d;
      weights_q   <= weights_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      cfg_valid_q <= cfg_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    flag_d      = flag_q;
    en_d        = en_q;
    weights_d   = weights_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    fail_d      = fail_q;
    cfg_valid_d = cfg_valid_q;
    // A legal WLEN holds F(NSIG+1), so the sum never wraps.
    sum         = a_q + b_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          flag_d      = bus.f_flag;
          en_d        = '0;
          weights_d   = '0;
          fail_d      = 1'b0;
          cfg_valid_d = 1'b0;
          idx_d       = '0;
          cnt_d       = '0;
          a_d         = '0;
          b_d         = WLEN'(1);
          busy_d      = 1'b1;
          state_d     = SCAN;
        end
      end
      SCAN: begin
        for (int i = 0; i < NTSV; i++) begin
          if (idx_q == IDXW'(i)) begin
            if (!flag_q[i] && (cnt_q < NSIG_C)) begin
              en_d[i]                  = 1'b1;
              weights_d[i*WLEN +: WLEN] = sum;
              a_d                      = b_q;
              b_d                      = sum;
              cnt_d                    = cnt_q + 1'b1;
            end else begin
              en_d[i]                  = 1'b0;
              weights_d[i*WLEN +: WLEN] = '0;
            end
          end
        end
        if (idx_q == LAST_IDX) begin
          state_d     = DONE;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          fail_d      = (cnt_d < NSIG_C);
          cfg_valid_d = (cnt_d >= NSIG_C);
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.fail      = fail_q;
  assign bus.cfg_valid = cfg_valid_q;
  assign bus.en_flag   = en_q;
  assign bus.weights   = weights_q;
endmodule

// File: tb/tb_fns_weight_sched.sv
// Scenario bench for fns_weight_sched: expected configurations are queued when a scan is
// requested and compared by a monitor whenever done pulses.
module tb_fns_weight_sched;
  localparam int NTSV = 5;
  localparam int NSIG = 3;
  localparam int WLEN = 4;

  typedef struct {
    logic [NTSV-1:0]      en;
    logic [NTSV*WLEN-1:0] w;
    logic                 fl;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];

  fns_weight_sched_if #(.NTSV(NTSV), .WLEN(WLEN)) bus ();

  fns_weight_sched #(.NTSV(NTSV), .NSIG(NSIG), .WLEN(WLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Scoreboard: every done pulse consumes one queued expectation.
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      exp_t e;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_empty: done seen with no expected result, en=%b", bus.en_flag);
      end else begin
        e = sb.pop_front();
        if (bus.en_flag !== e.en || bus.weights !== e.w || bus.fail !== e.fl ||
            bus.cfg_valid !== !e.fl || bus.busy !== 1'b0) begin
          bad++;
          $display("FAIL result: got en=%b w=%h fail=%b cfg_valid=%b busy=%b, want en=%b w=%h fail=%b cfg_valid=%b busy=0",
                   bus.en_flag, bus.weights, bus.fail, bus.cfg_valid, bus.busy, e.en, e.w, e.fl, !e.fl);
        end else begin
          $display("scan result en=%b w=%h fail=%b", bus.en_flag, bus.weights, bus.fail);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [NTSV-1:0] en, input logic [NTSV*WLEN-1:0] w, input logic fl);
    exp_t e;
    e.en = en;
    e.w  = w;
    e.fl = fl;
    sb.push_back(e);
  endtask

  // Reference: the k-th enabled healthy TSV gets the k-th Fibonacci weight 1,2,3,5,...
  function automatic exp_t model(input logic [NTSV-1:0] flags);
    int fibs[8] = '{1, 2, 3, 5, 8, 13, 21, 34};
    int used = 0;
    exp_t e;
    e.en = '0;
    e.w  = '0;
    for (int i = 0; i < NTSV; i++) begin
      if (!flags[i] && used < NSIG) begin
        e.en[i] = 1'b1;
        e.w[i*WLEN +: WLEN] = WLEN'(fibs[used]);
        used++;
      end
    end
    e.fl = (used < NSIG);
    return e;
  endfunction

  task automatic start_scan(input logic [NTSV-1:0] flags);
    bus.f_flag = flags;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
  endtask

  task automatic wait_done(output int nbusy);
    nbusy = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.done) return;
      if (bus.busy) nbusy++;
      tick();
    end
    total++;
    bad++;
    $display("FAIL timeout: done not seen within 40 cycles, busy=%b", bus.busy);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.f_flag = '0;
    repeat (3) tick();
    total++;
    if ({bus.busy, bus.done, bus.fail, bus.cfg_valid} !== 4'b0 || bus.en_flag !== '0 || bus.weights !== '0) begin
      bad++;
      $display("FAIL reset: busy=%b done=%b fail=%b cfg_valid=%b en=%b w=%h, want all zero",
               bus.busy, bus.done, bus.fail, bus.cfg_valid, bus.en_flag, bus.weights);
    end else $display("reset outputs zero");
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int nb;
    push(5'b00111, 20'h00321, 1'b0);
    start_scan(5'b00000);
    wait_done(nb);
    total++;
    if (nb !== NTSV) begin
      bad++;
      $display("FAIL busy_len: got %0d busy cycles, want %0d", nb, NTSV);
    end else $display("busy lasted %0d cycles", nb);
    tick();
    total++;
    if (bus.done !== 1'b0 || bus.cfg_valid !== 1'b1) begin
      bad++;
      $display("FAIL done_pulse: done=%b cfg_valid=%b after pulse, want done=0 cfg_valid=1", bus.done, bus.cfg_valid);
    end else $display("done pulse single cycle, outputs held");
  endtask

  task automatic test_patterns();
    int nb;
    push(5'b11010, 20'h32010, 1'b0);
    start_scan(5'b00101);
    wait_done(nb);
    tick();
    push(5'b10100, 20'h20100, 1'b1);
    start_scan(5'b01011);
    wait_done(nb);
    tick();
    push(5'b00000, 20'h00000, 1'b1);
    start_scan(5'b11111);
    wait_done(nb);
    tick();
    push(5'b11100, 20'h32100, 1'b0);
    start_scan(5'b00011);
    wait_done(nb);
    tick();
  endtask

  task automatic test_mid_reset();
    int nb;
    start_scan(5'b00000);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.en_flag !== '0 || bus.weights !== '0 || bus.cfg_valid !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: busy=%b done=%b en=%b w=%h cfg_valid=%b, want all zero",
               bus.busy, bus.done, bus.en_flag, bus.weights, bus.cfg_valid);
    end else $display("mid-scan reset cleared outputs");
    rst = 1'b0;
    nb = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (bus.busy || bus.done) nb++;
    end
    total++;
    if (nb !== 0) begin
      bad++;
      $display("FAIL idle_after_reset: %0d active cycles without start, want 0", nb);
    end else $display("idle after reset");
    push(5'b00111, 20'h00321, 1'b0);
    start_scan(5'b00000);
    wait_done(nb);
    tick();
  endtask

  task automatic test_ignore_and_restart();
    int nb;
    push(5'b00111, 20'h00321, 1'b0);
    start_scan(5'b00000);
    bus.f_flag = 5'b11111;
    for (int c = 0; c < 3; c++) begin
      bus.start = ~bus.start;
      tick();
    end
    bus.start = 1'b0;
    wait_done(nb);
    // Restart while done is still high.
    push(5'b11100, 20'h32100, 1'b0);
    bus.f_flag = 5'b00011;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    total++;
    if (bus.cfg_valid !== 1'b0 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      bad++;
      $display("FAIL restart: cfg_valid=%b busy=%b done=%b, want 0 1 0", bus.cfg_valid, bus.busy, bus.done);
    end else $display("restart from done accepted");
    wait_done(nb);
    tick();
  endtask

  task automatic test_back_to_back();
    int nb;
    for (int k = 0; k < 3; k++) push(5'b00111, 20'h00321, 1'b0);
    bus.f_flag = 5'b10000;
    bus.start = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) begin
      wait_done(nb);
      tick();
      if (k == 1) bus.start = 1'b0;
      total++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
        bad++;
        $display("FAIL b2b_%0d: busy=%b done=%b after done, want 1 0", k, bus.busy, bus.done);
      end else $display("back-to-back scan %0d started", k + 1);
    end
    wait_done(nb);
    tick();
  endtask

  task automatic test_random();
    int nb;
    logic [NTSV-1:0] f;
    for (int k = 0; k < 8; k++) begin
      f = NTSV'($urandom_range(0, 31));
      sb.push_back(model(f));
      start_scan(f);
      wait_done(nb);
      tick();
    end
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.f_flag = '0;
    test_reset();
    test_basic();
    test_patterns();
    test_mid_reset();
    test_ignore_and_restart();
    test_back_to_back();
    test_random();
    repeat (3) tick();
    total++;
    if (sb.size() !== 0) begin
      bad++;
      $display("FAIL sb_leftover: %0d expected results never produced, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
